// File: rtl/fc_layer_ctrl_if.sv
// Stream and datapath-control signals of the fully-connected layer sequencer.
// Handshakes (x in, y out): a transfer occurs on a rising clk edge where valid and ready are
// both high; valid never depends on ready, and a raised valid holds its payload until taken.
interface fc_layer_ctrl_if #(
  parameter int M = 32,
  parameter int N = 33,
  parameter int P = 8
);
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = ((M / P) * N > 1) ? $clog2((M / P) * N) : 1;
  localparam int SW = (P > 1) ? $clog2(P) : 1;

  logic          s_valid_x;
  logic          s_ready_x;
  logic          x_wr_en;
  logic [XW-1:0] x_addr;
  logic [WW-1:0] w_addr;
  logic          clr_acc;
  logic          en_acc;
  logic [SW-1:0] out_sel;
  logic          m_valid_y;
  logic          m_ready_y;
  logic          busy;
  logic [2:0]    dbg_state;

  modport master (
    input  s_valid_x, m_ready_y,
    output s_ready_x, x_wr_en, x_addr, w_addr, clr_acc, en_acc, out_sel,
           m_valid_y, busy, dbg_state
  );

  modport slave (
    output s_valid_x, m_ready_y,
    input  s_ready_x, x_wr_en, x_addr, w_addr, clr_acc, en_acc, out_sel,
           m_valid_y, busy, dbg_state
  );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer y = W*x on P MAC lanes: load x, then per group of
// P rows clear, step and drain the lanes and stream the P results out one at a time.
module fc_layer_ctrl #(
  parameter int M   = 32,
  parameter int N   = 33,
  parameter int P   = 8,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  fc_layer_ctrl_if.master bus
);
  localparam int G  = M / P;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (G * N > 1) ? $clog2(G * N) : 1;
  localparam int SW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(N - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [SW-1:0] L_LAST = SW'(P - 1);
  localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);

  if (M % P != 0) begin : g_bad_mp
    $error("fc_layer_ctrl: M must be a multiple of P");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("fc_layer_ctrl: LAT must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t        state_q;
  logic [XW-1:0] j_q;
  logic [XW-1:0] k_q;
  logic [GW-1:0] g_q;
  logic [SW-1:0] lane_q;
  logic [DW-1:0] drain_q;
  logic          s_ready_q;
  logic          clr_q;
  logic          en_q;
  logic          m_valid_q;
  logic          busy_q;

  logic x_hs;
  logic y_hs;
  logic in_mac;

  assign x_hs   = bus.s_valid_x & s_ready_q;
  assign y_hs   = m_valid_q & bus.m_ready_y;
  assign in_mac = (state_q == ST_MAC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_LOAD;
      j_q       <= '0;
      k_q       <= '0;
      g_q       <= '0;
      lane_q    <= '0;
      drain_q   <= '0;
      s_ready_q <= 1'b1;
      clr_q     <= 1'b0;
      en_q      <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Lanes see RAM/ROM data one cycle after the address, so enable trails MAC by one.
      en_q <= in_mac;
      case (state_q)
        ST_LOAD: begin
          if (x_hs) begin
            if (j_q == X_LAST) begin
              j_q       <= '0;
              state_q   <= ST_CLR;
              s_ready_q <= 1'b0;
              clr_q     <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        ST_CLR: begin
          clr_q   <= 1'b0;
          k_q     <= '0;
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          if (k_q == X_LAST) begin
            k_q     <= '0;
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == D_LAST) begin
            drain_q   <= '0;
            lane_q    <= '0;
            m_valid_q <= 1'b1;
            state_q   <= ST_OUT;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (y_hs) begin
            if (lane_q == L_LAST) begin
              lane_q    <= '0;
              m_valid_q <= 1'b0;
              if (g_q == G_LAST) begin
                g_q       <= '0;
                state_q   <= ST_LOAD;
                s_ready_q <= 1'b1;
                busy_q    <= 1'b0;
              end else begin
                g_q     <= g_q + 1'b1;
                state_q <= ST_CLR;
                clr_q   <= 1'b1;
              end
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // j and k are both held at zero outside their own state, so the mux needs no third arm.
  assign bus.x_addr    = in_mac ? k_q : j_q;
  assign bus.w_addr    = in_mac ? (WW'(g_q) * WW'(N) + WW'(k_q)) : '0;
  assign bus.x_wr_en   = x_hs;
  assign bus.s_ready_x = s_ready_q;
  assign bus.clr_acc   = clr_q;
  assign bus.en_acc    = en_q;
  assign bus.out_sel   = lane_q;
  assign bus.m_valid_y = m_valid_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: directed sequencing checks on a 4x3/P=2 instance and a random
// 50-vector W*x run on a 32x33/P=8 instance, both scored against a lane datapath model.
module tb_fc_layer_ctrl;
  localparam int SM   = 4;
  localparam int SN   = 3;
  localparam int SP   = 2;
  localparam int SG   = SM / SP;
  localparam int BM   = 32;
  localparam int BN   = 33;
  localparam int BP   = 8;
  localparam int BG   = BM / BP;
  localparam int LAT  = 2;
  localparam int NVEC = 50;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_ctrl_if #(.M(SM), .N(SN), .P(SP)) s_if ();
  fc_layer_ctrl_if #(.M(BM), .N(BN), .P(BP)) b_if ();

  fc_layer_ctrl #(.M(SM), .N(SN), .P(SP), .LAT(LAT)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.master)
  );

  fc_layer_ctrl #(.M(BM), .N(BN), .P(BP), .LAT(LAT)) u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  // ---------------- lane datapath models ----------------
  // ROM layout: lane l at address g*N+k holds W[g*P+l][k]; RAM read latency is one cycle.
  int s_xdata;
  int s_wmat [SM][SN];
  int s_wrom [SP][SG*SN];
  int s_xram [SN];
  int s_acc  [SP];
  int s_xa_d, s_wa_d;

  int b_xdata;
  int b_wmat [BM][BN];
  int b_wrom [BP][BG*BN];
  int b_xram [BN];
  int b_acc  [BP];
  int b_xa_d, b_wa_d;

  always @(posedge clk) begin
    if (s_if.x_wr_en) s_xram[s_if.x_addr] <= s_xdata;
    for (int l = 0; l < SP; l++) begin
      if (s_if.clr_acc) s_acc[l] <= 0;
      else if (s_if.en_acc) s_acc[l] <= s_acc[l] + s_xram[s_xa_d] * s_wrom[l][s_wa_d];
    end
    s_xa_d <= int'(s_if.x_addr);
    s_wa_d <= int'(s_if.w_addr);
  end

  always @(posedge clk) begin
    if (b_if.x_wr_en) b_xram[b_if.x_addr] <= b_xdata;
    for (int l = 0; l < BP; l++) begin
      if (b_if.clr_acc) b_acc[l] <= 0;
      else if (b_if.en_acc) b_acc[l] <= b_acc[l] + b_xram[b_xa_d] * b_wrom[l][b_wa_d];
    end
    b_xa_d <= int'(b_if.x_addr);
    b_wa_d <= int'(b_if.w_addr);
  end

  // ---------------- scoreboards / monitors ----------------
  logic [31:0] s_exp_q[$];
  logic [31:0] b_exp_q[$];
  int s_wr_q[$], s_clr_q[$], s_en_q[$], s_ax_q[$], s_aw_q[$], s_sel_q[$];
  int s_accept_last;
  logic s_hold_v = 1'b0;
  int   s_hold_sel;
  logic b_hold_v = 1'b0;
  int   b_hold_sel;
  int   b_got = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (s_hold_v) begin
        check_eq("s_valid_hold", s_if.m_valid_y, 1);
        check_eq("s_sel_hold", s_if.out_sel, s_hold_sel);
      end
      if (s_if.clr_acc) check_eq("s_clr_en_excl", s_if.en_acc, 0);
      if (s_if.x_wr_en) begin
        s_wr_q.push_back(int'(s_if.x_addr));
        s_accept_last = cyc;
      end
      if (s_if.clr_acc) s_clr_q.push_back(cyc);
      if (s_if.en_acc) begin
        s_en_q.push_back(cyc);
        s_ax_q.push_back(s_xa_d);
        s_aw_q.push_back(s_wa_d);
      end
      if (s_if.m_valid_y && s_if.m_ready_y) begin
        s_sel_q.push_back(int'(s_if.out_sel));
        check_eq("s_y_expected", s_exp_q.size() > 0, 1);
        if (s_exp_q.size() > 0) check_eq("s_y", s_acc[s_if.out_sel], s_exp_q.pop_front());
      end
    end
    s_hold_v   = reset && s_if.m_valid_y && !s_if.m_ready_y;
    s_hold_sel = int'(s_if.out_sel);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (b_hold_v) begin
        check_eq("b_valid_hold", b_if.m_valid_y, 1);
        check_eq("b_sel_hold", b_if.out_sel, b_hold_sel);
      end
      if (b_if.clr_acc) check_eq("b_clr_en_excl", b_if.en_acc, 0);
      if (b_if.m_valid_y && b_if.m_ready_y) begin
        b_got++;
        check_eq("b_y_expected", b_exp_q.size() > 0, 1);
        if (b_exp_q.size() > 0) check_eq("b_y", b_acc[b_if.out_sel], b_exp_q.pop_front());
      end
    end
    b_hold_v   = reset && b_if.m_valid_y && !b_if.m_ready_y;
    b_hold_sel = int'(b_if.out_sel);
  end

  // ---------------- driver tasks ----------------
  // Streams one vector into the small instance; called and returning at posedge+1.
  task automatic small_vector(input int xv[SN], input bit gap, input int stall,
                              input int abort_at, output int lat);
    int idx, t0, stall_left, c, sum;
    logic prev_v;
    idx = 0; t0 = -1; stall_left = 0; c = 0; prev_v = 1'b0; lat = -1;
    s_wr_q.delete(); s_clr_q.delete(); s_en_q.delete();
    s_ax_q.delete(); s_aw_q.delete(); s_sel_q.delete();
    for (int r = 0; r < SM; r++) begin
      sum = 0;
      for (int k = 0; k < SN; k++) sum += s_wmat[r][k] * xv[k];
      s_exp_q.push_back(sum);
    end
    while (c < 300) begin
      if (abort_at >= 0 && t0 >= 0 && cyc == t0 + abort_at) begin
        reset = 1'b0;
        s_if.s_valid_x = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_s_ready", s_if.s_ready_x, 1);
        check_eq("t5_en_acc", s_if.en_acc, 0);
        check_eq("t5_x_addr", s_if.x_addr, 0);
        check_eq("t5_busy", s_if.busy, 0);
        check_eq("t5_m_valid", s_if.m_valid_y, 0);
        check_eq("t5_clr_acc", s_if.clr_acc, 0);
        s_exp_q.delete();
        @(posedge clk); #1;
        return;
      end
      if (idx < SN) begin
        s_if.s_valid_x = gap ? ((c % 2) == 0) : 1'b1;
        s_xdata = xv[idx];
      end else begin
        s_if.s_valid_x = 1'b0;
      end
      if (s_if.m_valid_y && !prev_v) stall_left = stall;
      prev_v = s_if.m_valid_y;
      s_if.m_ready_y = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (idx == SN && s_if.s_ready_x) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
      if (s_if.x_wr_en) begin
        if (t0 < 0) t0 = cyc;
        idx++;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic check_trace(input string t, input int period);
    check_eq({t, "_wr_n"}, s_wr_q.size(), SN);
    foreach (s_wr_q[i]) check_eq({t, "_wr_addr"}, s_wr_q[i], i);
    check_eq({t, "_clr_n"}, s_clr_q.size(), SG);
    check_eq({t, "_en_n"}, s_en_q.size(), SG * SN);
    check_eq({t, "_sel_n"}, s_sel_q.size(), SM);
    if (s_clr_q.size() == SG) begin
      check_eq({t, "_clr_after_load"}, s_clr_q[0], s_accept_last + 1);
      for (int g = 1; g < SG; g++)
        check_eq({t, "_group_period"}, s_clr_q[g] - s_clr_q[g-1], period);
      if (s_en_q.size() == SG * SN) begin
        foreach (s_en_q[i]) begin
          check_eq({t, "_en_cycle"}, s_en_q[i], s_clr_q[i / SN] + 2 + (i % SN));
          check_eq({t, "_x_rd_addr"}, s_ax_q[i], i % SN);
          check_eq({t, "_w_addr"}, s_aw_q[i], i);
        end
      end
    end
    foreach (s_sel_q[i]) check_eq({t, "_out_sel"}, s_sel_q[i], i % SP);
    check_eq({t, "_y_left"}, s_exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int bx [NVEC][BN];

  initial begin
    int lat, sum, b_limit;
    int xv[SN];
    bit x_done;
    s_if.s_valid_x = 1'b0;
    s_if.m_ready_y = 1'b1;
    b_if.s_valid_x = 1'b0;
    b_if.m_ready_y = 1'b1;
    s_xdata = 0;
    b_xdata = 0;
    for (int r = 0; r < SM; r++)
      for (int k = 0; k < SN; k++) begin
        s_wmat[r][k] = int'($urandom_range(0, 15)) - 8;
        s_wrom[r % SP][(r / SP) * SN + k] = s_wmat[r][k];
      end
    for (int r = 0; r < BM; r++)
      for (int k = 0; k < BN; k++) begin
        b_wmat[r][k] = int'($urandom_range(0, 255)) - 128;
        b_wrom[r % BP][(r / BP) * BN + k] = b_wmat[r][k];
      end

    // Test 1: reset low for three cycles.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("t1_s_ready", s_if.s_ready_x, 1);
    check_eq("t1_busy", s_if.busy, 0);
    check_eq("t1_m_valid", s_if.m_valid_y, 0);
    check_eq("t1_clr_acc", s_if.clr_acc, 0);
    check_eq("t1_en_acc", s_if.en_acc, 0);
    check_eq("t1_x_addr", s_if.x_addr, 0);
    check_eq("t1_w_addr", s_if.w_addr, 0);
    check_eq("t1_out_sel", s_if.out_sel, 0);
    check_eq("t1_big_s_ready", b_if.s_ready_x, 1);
    @(posedge clk); #1;

    // Test 2: dense input, downstream always ready.
    xv = '{5, -2, 7};
    small_vector(xv, 1'b0, 0, -1, lat);
    check_eq("t2_latency", lat, SN + SG * (1 + SN + LAT + SP));
    check_trace("t2", 1 + SN + LAT + SP);

    // Test 3: downstream stalls four cycles at each OUT entry.
    xv = '{int'($urandom_range(0, 15)) - 8, 3, -6};
    small_vector(xv, 1'b0, 4, -1, lat);
    check_eq("t3_latency", lat, SN + SG * (1 + SN + LAT + SP) + 8);
    check_trace("t3", 1 + SN + LAT + SP + 4);

    // Test 4: input valid toggling.
    xv = '{-1, 4, 2};
    small_vector(xv, 1'b1, 0, -1, lat);
    check_eq("t4_latency", lat, 2 * SN - 1 + SG * (1 + SN + LAT + SP));
    check_trace("t4", 1 + SN + LAT + SP);

    // Test 5: reset pulse in the second MAC cycle of group 1, then a fresh vector.
    xv = '{7, 7, -3};
    small_vector(xv, 1'b0, 0, SN + (1 + SN + LAT + SP) + 2, lat);
    xv = '{5, -2, 7};
    small_vector(xv, 1'b0, 0, -1, lat);
    check_eq("t5_latency", lat, SN + SG * (1 + SN + LAT + SP));
    check_trace("t5", 1 + SN + LAT + SP);

    // Test 6: random W*x, random valid/ready, 50 back-to-back vectors on the large instance.
    for (int v = 0; v < NVEC; v++)
      for (int k = 0; k < BN; k++) bx[v][k] = int'($urandom_range(0, 255)) - 128;
    for (int v = 0; v < NVEC; v++)
      for (int r = 0; r < BM; r++) begin
        sum = 0;
        for (int k = 0; k < BN; k++) sum += b_wmat[r][k] * bx[v][k];
        b_exp_q.push_back(sum);
      end
    b_limit = cyc + 60000;
    fork
      begin
        for (int v = 0; v < NVEC; v++)
          for (int k = 0; k < BN; k++) begin
            x_done = 1'b0;
            while (!x_done && cyc < b_limit) begin
              b_xdata = bx[v][k];
              b_if.s_valid_x = ($urandom_range(0, 3) != 0);
              @(negedge clk);
              x_done = b_if.x_wr_en;
              @(posedge clk); #1;
            end
          end
        b_if.s_valid_x = 1'b0;
      end
      begin
        while (b_got < NVEC * BM && cyc < b_limit) begin
          b_if.m_ready_y = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        b_if.m_ready_y = 1'b1;
      end
    join
    check_eq("t6_y_count", b_got, NVEC * BM);
    check_eq("t6_y_left", b_exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t6_idle_ready", b_if.s_ready_x, 1);
    check_eq("t6_idle_busy", b_if.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
